// File: rtl/ufm_fault_log_arb.sv
// ufm_fault_log_arb
// Serialises MSTR_SEQ power-sequence fault events into single 32-bit records
// for the UFM write port, one flash write in flight at a time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no write in flight; round-robin grant when a fault is pending
// ST_ISSUE | oUFM_WR held with stable addr/data until iUFM_WAITREQ drops
// ST_PROG  | write accepted; waiting for iUFM_BUSY to clear or time out
//
// Record: [31:24] seq#, [23:20] fault id, [19:16] state snapshot, [15:0] ms stamp.

module ufm_fault_log_arb #(
   parameter int NUM_FLT   = 7,
   parameter int ADDR_W    = 12,
   parameter int LOG_BASE  = 0,
   parameter int LOG_DEPTH = 64,
   parameter int WRAP_EN   = 1,
   parameter int BUSY_TO   = 4000
) (
   input  logic                iClk,
   input  logic                iRst_n,
   input  logic                iTick_1ms,
   input  logic [NUM_FLT-1:0]  iFLT_N,
   input  logic [3:0]          iSEQ_STATE,
   input  logic                iLog_Clear,
   output logic                oUFM_WR,
   output logic [ADDR_W-1:0]   oUFM_ADDR,
   output logic [31:0]         oUFM_WDATA,
   input  logic                iUFM_WAITREQ,
   input  logic                iUFM_BUSY,
   output logic [ADDR_W:0]     oLog_Count,
   output logic                oLog_Full,
   output logic                oUFM_Err,
   output logic [NUM_FLT-1:0]  oPending
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int TO_W  = $clog2(BUSY_TO + 1);
   localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(LOG_BASE);
   localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(LOG_BASE + LOG_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(LOG_DEPTH);
   localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(BUSY_TO);
   localparam logic [3:0]        LAST_ID   = 4'(NUM_FLT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_PROG} state_t;

   state_t              state_q, state_d;
   logic [NUM_FLT-1:0]  flt_q, flt_d;
   logic [NUM_FLT-1:0]  flt_prev_q, flt_prev_d;
   logic [NUM_FLT-1:0]  pend_q, pend_d;
   logic [NUM_FLT-1:0]  logged_q, logged_d;
   logic [3:0]          slot_st_q [NUM_FLT];
   logic [3:0]          slot_st_d [NUM_FLT];
   logic [15:0]         slot_ts_q [NUM_FLT];
   logic [15:0]         slot_ts_d [NUM_FLT];
   logic [15:0]         ts_q, ts_d;
   logic [7:0]          seq_q, seq_d;
   logic [3:0]          rr_q, rr_d;
   logic [3:0]          gnt_q, gnt_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic                sup_q, sup_d;

   logic                gnt_found;
   logic [3:0]          gnt_sel;
   logic [3:0]          sel_st;
   logic [15:0]         sel_ts;
   logic [NUM_FLT-1:0]  gnt_oh;
   logic                full;
   logic                grant;
   logic                accept;
   logic [NUM_FLT-1:0]  acc_oh;
   logic [NUM_FLT-1:0]  new_evt;

   assign full   = (cnt_q == CNT_MAX);
   assign grant  = (state_q == ST_IDLE) && (pend_q != '0) && ((WRAP_EN != 0) || !full);
   assign accept = (state_q == ST_ISSUE) && !iUFM_WAITREQ;

   // Round-robin pick: first pending index at or after rr_q, wrapping; also mux its slot.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_sel   = '0;
      sel_st    = '0;
      sel_ts    = '0;
      gnt_oh    = '0;
      for (int k = 0; k < NUM_FLT; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_FLT) idx = idx - NUM_FLT;
         for (int i = 0; i < NUM_FLT; i++) begin
            if (!gnt_found && (i == idx) && pend_q[i]) begin
               gnt_found = 1'b1;
               gnt_sel   = 4'(i);
            end
         end
      end
      for (int i = 0; i < NUM_FLT; i++) begin
         if (gnt_sel == 4'(i)) begin
            sel_st = slot_st_q[i];
            sel_ts = slot_ts_q[i];
         end
         gnt_oh[i] = (gnt_q == 4'(i));
      end
   end

   // Edge capture, arbitration FSM, log pointer/count and clear handling.
   always_comb begin
      state_d    = state_q;
      flt_d      = iFLT_N;
      flt_prev_d = flt_q;
      pend_d     = pend_q;
      logged_d   = logged_q;
      slot_st_d  = slot_st_q;
      slot_ts_d  = slot_ts_q;
      ts_d       = ts_q + 16'(iTick_1ms);
      seq_d      = seq_q;
      rr_d       = rr_q;
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      to_d       = to_q;

      acc_oh  = accept ? gnt_oh : '0;
      // the fault being accepted this cycle is treated as already logged
      new_evt = flt_prev_q & ~flt_q & ~logged_q & ~acc_oh;
      pend_d  = pend_q | new_evt;
      for (int i = 0; i < NUM_FLT; i++) begin
         if (new_evt[i]) begin
            slot_st_d[i] = iSEQ_STATE;
            slot_ts_d[i] = ts_q;
         end
      end

      // a clear that lands while a record is being issued detaches that record
      // from the new log epoch: it still goes out, but does not advance ptr/count
      sup_d = (sup_q && !accept) ||
              (iLog_Clear && (grant || ((state_q == ST_ISSUE) && !accept)));

      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               wr_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = {seq_q, gnt_sel, sel_st, sel_ts};
               gnt_d   = gnt_sel;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (accept) begin
               wr_d    = 1'b0;
               seq_d   = seq_q + 8'd1;
               rr_d    = (gnt_q == LAST_ID) ? 4'd0 : gnt_q + 4'd1;
               to_d    = TO_LOAD;
               state_d = ST_PROG;
               if (!sup_q && !iLog_Clear) begin
                  pend_d   = pend_d & ~acc_oh;
                  logged_d = logged_q | acc_oh;
                  ptr_d    = (ptr_q == PTR_LAST) ? PTR_FIRST : ptr_q + ADDR_W'(1);
                  if (!full) cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_PROG: begin
            if (!iUFM_BUSY) begin
               state_d = ST_IDLE;
            end else if (to_q <= TO_W'(1)) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               to_d = to_q - TO_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (iLog_Clear) begin
         pend_d   = '0;
         logged_d = '0;
         cnt_d    = '0;
         ptr_d    = PTR_FIRST;
      end
   end

   // State and datapath registers.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q    <= ST_IDLE;
         flt_q      <= '1;
         flt_prev_q <= '1;
         pend_q     <= '0;
         logged_q   <= '0;
         for (int i = 0; i < NUM_FLT; i++) begin
            slot_st_q[i] <= '0;
            slot_ts_q[i] <= '0;
         end
         ts_q       <= '0;
         seq_q      <= '0;
         rr_q       <= '0;
         gnt_q      <= '0;
         ptr_q      <= PTR_FIRST;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= PTR_FIRST;
         wdata_q    <= '0;
         to_q       <= '0;
         sup_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         flt_q      <= flt_d;
         flt_prev_q <= flt_prev_d;
         pend_q     <= pend_d;
         logged_q   <= logged_d;
         slot_st_q  <= slot_st_d;
         slot_ts_q  <= slot_ts_d;
         ts_q       <= ts_d;
         seq_q      <= seq_d;
         rr_q       <= rr_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         to_q       <= to_d;
         sup_q      <= sup_d;
      end
   end

   assign oUFM_WR    = wr_q;
   assign oUFM_ADDR  = addr_q;
   assign oUFM_WDATA = wdata_q;
   assign oLog_Count = cnt_q;
   assign oLog_Full  = full;
   assign oUFM_Err   = err_q;
   assign oPending   = pend_q;

endmodule

// File: tb/tb_ufm_fault_log_arb.sv
// Bench for ufm_fault_log_arb: two instances (wrapping log at 0x100, and a
// non-wrapping log at 0), both depth 4, share stimulus and are checked every
// cycle against a record-level model of the logger.

module tb_ufm_fault_log_arb;

   localparam int NF    = 7;
   localparam int AW    = 12;
   localparam int DEPTH = 4;
   localparam int BTO   = 4000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic          clr = 1'b0;
   logic          waitreq = 1'b0;
   logic          busy = 1'b0;
   logic [NF-1:0] flt_n = '1;
   logic [3:0]    seq_state = 4'd0;

   logic          a_wr, b_wr;
   logic [AW-1:0] a_addr, b_addr;
   logic [31:0]   a_wdata, b_wdata;
   logic [AW:0]   a_cnt, b_cnt;
   logic          a_full, b_full, a_err, b_err;
   logic [NF-1:0] a_pend, b_pend;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   ufm_fault_log_arb #(.NUM_FLT(NF), .ADDR_W(AW), .LOG_BASE(256), .LOG_DEPTH(DEPTH),
                       .WRAP_EN(1), .BUSY_TO(BTO)) dut_a (
      .iClk(clk), .iRst_n(rst_n), .iTick_1ms(tick), .iFLT_N(flt_n), .iSEQ_STATE(seq_state),
      .iLog_Clear(clr), .oUFM_WR(a_wr), .oUFM_ADDR(a_addr), .oUFM_WDATA(a_wdata),
      .iUFM_WAITREQ(waitreq), .iUFM_BUSY(busy), .oLog_Count(a_cnt), .oLog_Full(a_full),
      .oUFM_Err(a_err), .oPending(a_pend));

   ufm_fault_log_arb #(.NUM_FLT(NF), .ADDR_W(AW), .LOG_BASE(0), .LOG_DEPTH(DEPTH),
                       .WRAP_EN(0), .BUSY_TO(BTO)) dut_b (
      .iClk(clk), .iRst_n(rst_n), .iTick_1ms(tick), .iFLT_N(flt_n), .iSEQ_STATE(seq_state),
      .iLog_Clear(clr), .oUFM_WR(b_wr), .oUFM_ADDR(b_addr), .oUFM_WDATA(b_wdata),
      .iUFM_WAITREQ(waitreq), .iUFM_BUSY(busy), .oLog_Count(b_cnt), .oLog_Full(b_full),
      .oUFM_Err(b_err), .oPending(b_pend));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // phase: 0 = no write outstanding, 1 = request posted, 2 = flash programming
   int            m_ph   [2];
   logic [NF-1:0] m_h1   [2];
   logic [NF-1:0] m_h2   [2];
   logic [NF-1:0] m_pend [2];
   logic [NF-1:0] m_logd [2];
   logic [3:0]    m_st   [2][NF];
   logic [15:0]   m_tsl  [2][NF];
   logic [15:0]   m_ts   [2];
   logic [7:0]    m_seq  [2];
   int            m_rr   [2];
   int            m_g    [2];
   int            m_nwr  [2];
   bit            m_sup  [2];
   int            m_pc   [2];
   bit            m_err  [2];
   bit            m_wr   [2];
   logic [AW-1:0] m_addr [2];
   logic [31:0]   m_data [2];

   function automatic logic [AW-1:0] base_of(input int u);
      return (u == 0) ? 12'h100 : 12'h000;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_ph[u] = 0; m_h1[u] = '1; m_h2[u] = '1; m_pend[u] = '0; m_logd[u] = '0;
         for (int i = 0; i < NF; i++) begin m_st[u][i] = '0; m_tsl[u][i] = '0; end
         m_ts[u] = '0; m_seq[u] = '0; m_rr[u] = 0; m_g[u] = 0; m_nwr[u] = 0;
         m_sup[u] = 0; m_pc[u] = 0; m_err[u] = 0; m_wr[u] = 0;
         m_addr[u] = base_of(u); m_data[u] = '0;
      end
   endtask

   task automatic model_step(input int u);
      bit acc, gr, sup_n;
      int g;
      logic [31:0] gdata;
      acc = (m_ph[u] == 1) && !waitreq;
      gr  = (m_ph[u] == 0) && (m_pend[u] != '0) && ((u == 0) || (m_nwr[u] < DEPTH));
      g   = -1;
      for (int k = 0; k < NF; k++) begin
         int idx;
         idx = (m_rr[u] + k) % NF;
         if (g < 0 && m_pend[u][idx]) g = idx;
      end
      gdata = '0;
      if (gr) gdata = {m_seq[u], 4'(g), m_st[u][g], m_tsl[u][g]};
      for (int i = 0; i < NF; i++) begin
         if (m_h2[u][i] && !m_h1[u][i] && !m_logd[u][i] && !(acc && m_g[u] == i)) begin
            m_pend[u][i] = 1'b1;
            m_st[u][i]   = seq_state;
            m_tsl[u][i]  = m_ts[u];
         end
      end
      m_h2[u] = m_h1[u];
      m_h1[u] = flt_n;
      if (tick) m_ts[u] = m_ts[u] + 16'd1;
      sup_n = (m_sup[u] && !acc) || (clr && (gr || (m_ph[u] == 1 && !acc)));
      if (m_ph[u] == 0) begin
         if (gr) begin
            m_wr[u] = 1; m_addr[u] = base_of(u) + AW'(m_nwr[u] % DEPTH);
            m_data[u] = gdata; m_g[u] = g; m_ph[u] = 1;
         end
      end else if (m_ph[u] == 1) begin
         if (acc) begin
            m_wr[u] = 0; m_seq[u] = m_seq[u] + 8'd1; m_rr[u] = (m_g[u] + 1) % NF;
            m_pc[u] = 0; m_ph[u] = 2;
            if (!m_sup[u] && !clr) begin
               m_pend[u][m_g[u]] = 1'b0; m_logd[u][m_g[u]] = 1'b1; m_nwr[u]++;
            end
         end
      end else begin
         if (!busy) m_ph[u] = 0;
         else begin
            m_pc[u]++;
            if (m_pc[u] == BTO) begin m_err[u] = 1; m_ph[u] = 0; end
         end
      end
      if (clr) begin m_pend[u] = '0; m_logd[u] = '0; m_nwr[u] = 0; end
      m_sup[u] = sup_n;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else begin model_step(0); model_step(1); end
   end

   task automatic cmp_inst(input int u, input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] data, input logic [AW:0] cnt, input logic full,
                           input logic err, input logic [NF-1:0] pend);
      int ecnt;
      string p;
      p    = (u == 0) ? "a" : "b";
      ecnt = (m_nwr[u] > DEPTH) ? DEPTH : m_nwr[u];
      chk({p, ".wr"},    32'(wr),   32'(m_wr[u]));
      chk({p, ".count"}, 32'(cnt),  32'(ecnt));
      chk({p, ".full"},  32'(full), 32'(ecnt == DEPTH));
      chk({p, ".err"},   32'(err),  32'(m_err[u]));
      chk({p, ".pend"},  32'(pend), 32'(m_pend[u]));
      if (m_wr[u]) begin
         chk({p, ".addr"},  32'(addr), 32'(m_addr[u]));
         chk({p, ".wdata"}, data,      m_data[u]);
      end
   endtask

   always @(posedge clk) begin
      #1;
      cmp_inst(0, a_wr, a_addr, a_wdata, a_cnt, a_full, a_err, a_pend);
      cmp_inst(1, b_wr, b_addr, b_wdata, b_cnt, b_full, b_err, b_pend);
   end

   // accepted-write observation on instance a
   int            acc_id1 = 0;
   logic [AW-1:0] last_acc_addr_a = '0;
   always @(posedge clk) begin
      if (rst_n && a_wr && !waitreq) begin
         if (a_wdata[23:20] == 4'd1) acc_id1++;
         last_acc_addr_a = a_addr;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0; flt_n = '1; tick = 0; clr = 0; waitreq = 0; busy = 0; seq_state = 0;
      cyc(2);
      rst_n = 1;
   endtask

   task automatic wait_a_wr(input int lim, input logic val, output bit ok);
      ok = 0;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk); #1;
         if (a_wr == val) begin ok = 1; break; end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit ok;
      int base1;
      model_reset();
      @(posedge clk); #1;
      chk("rst.wr", 32'(a_wr), 32'd0);
      chk("rst.addr", 32'(a_addr), 32'h100);
      chk("rst.wdata", a_wdata, 32'h0);
      chk("rst.count", 32'(a_cnt), 32'd0);
      chk("rst.pend", 32'(a_pend), 32'd0);
      do_reset();

      // single fault: latency, record contents, count after accept
      repeat (16) begin @(negedge clk); tick = 1; @(negedge clk); tick = 0; end
      seq_state = 4'd5;
      @(negedge clk); flt_n[2] = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("t1.wr", 32'(a_wr), 32'd1);
      chk("t1.addr_a", 32'(a_addr), 32'h100);
      chk("t1.addr_b", 32'(b_addr), 32'h000);
      chk("t1.wdata", a_wdata, 32'h0025_0010);
      @(posedge clk); #1;
      chk("t1.count", 32'(a_cnt), 32'd1);
      cyc(6);

      // simultaneous faults 0 and 4 under back-pressure
      do_reset();
      waitreq = 1;
      @(negedge clk); flt_n[0] = 0; flt_n[4] = 0;
      wait_a_wr(10, 1'b1, ok);
      chk("t2.first_wr", 32'(ok), 32'd1);
      chk("t2.first_rec", 32'(a_wdata[31:20]), 32'h000);
      cyc(5);
      chk("t2.held_wr", 32'(a_wr), 32'd1);
      chk("t2.held_rec", 32'(a_wdata[31:20]), 32'h000);
      waitreq = 0;
      wait_a_wr(5, 1'b0, ok);
      wait_a_wr(10, 1'b1, ok);
      chk("t2.second_wr", 32'(ok), 32'd1);
      chk("t2.second_rec", 32'(a_wdata[31:20]), 32'h014);
      cyc(8);

      // level held low never re-triggers; clear re-arms
      do_reset();
      base1 = acc_id1;
      @(negedge clk); flt_n[1] = 0;
      cyc(1000); flt_n[1] = 1; cyc(3); flt_n[1] = 0; cyc(20);
      clr = 1; cyc(1); clr = 0; cyc(5);
      flt_n[1] = 1; cyc(3); flt_n[1] = 0; cyc(20);
      chk("t3.id1_records", 32'(acc_id1 - base1), 32'd2);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if ($urandom_range(15) == 0) begin
            int j;
            j = $urandom_range(NF - 1);
            flt_n[j] = ~flt_n[j];
         end
         seq_state = 4'($urandom);
         tick      = ($urandom_range(7) == 0);
         waitreq   = ($urandom_range(2) == 0);
         busy      = ($urandom_range(1) == 1);
         clr       = ($urandom_range(149) == 0);
      end
      @(negedge clk); tick = 0; clr = 0; waitreq = 0; busy = 0;
      cyc(30);

      // five faults into a depth-4 log
      do_reset();
      @(negedge clk); flt_n[4:0] = 5'b0;
      cyc(40);
      chk("t4.b_count", 32'(b_cnt), 32'd4);
      chk("t4.b_full", 32'(b_full), 32'd1);
      chk("t4.b_pend", 32'(b_pend), 32'h10);
      chk("t4.a_count", 32'(a_cnt), 32'd4);
      chk("t4.a_pend", 32'(a_pend), 32'd0);
      chk("t4.a_wrap_addr", 32'(last_acc_addr_a), 32'h100);

      // busy stuck high: timeout, then next record still goes out
      do_reset();
      busy = 1;
      @(negedge clk); flt_n[3] = 0; flt_n[5] = 0;
      ok = 0;
      for (int i = 0; i < 4100; i++) begin
         @(posedge clk); #1;
         if (a_err) begin ok = 1; break; end
      end
      chk("t5.timeout_err", 32'(ok), 32'd1);
      wait_a_wr(10, 1'b1, ok);
      chk("t5.next_wr", 32'(ok), 32'd1);
      chk("t5.next_id", 32'(a_wdata[23:20]), 32'd5);
      cyc(3);
      busy = 0;
      cyc(5);
      chk("t5.count", 32'(a_cnt), 32'd2);

      // reset asserted mid-ISSUE
      @(negedge clk); waitreq = 1; flt_n[6] = 0;
      wait_a_wr(10, 1'b1, ok);
      chk("t6.issue_wr", 32'(ok), 32'd1);
      @(negedge clk); rst_n = 0;
      #1;
      chk("t6.wr", 32'(a_wr), 32'd0);
      chk("t6.addr", 32'(a_addr), 32'h100);
      chk("t6.wdata", a_wdata, 32'h0);
      chk("t6.count", 32'(a_cnt), 32'd0);
      chk("t6.err", 32'(a_err), 32'd0);
      chk("t6.pend", 32'(a_pend), 32'd0);
      cyc(2);
      rst_n = 1; waitreq = 0;
      cyc(20);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
